mips_control_unit: RTL and testbench

//   Main decoder of the pipelined MIPS CPU, in the ID stage.

---
 rtl/mips_control_unit.sv | 157 +++++++++++++++
 tb/tb_mips_control_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mips_control_unit.sv
// Main ID-stage decoder: opcode/funct to registered datapath controls, one cycle of latency.
// Unrecognised opcodes decode as a NOP with every control low.
module mips_control_unit #(
  parameter int NB_OPCODE = 6,
  parameter int NB_FUNCT  = 6
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [NB_OPCODE-1:0] i_opcode,
  input  logic [NB_FUNCT-1:0]  i_funct,
  output logic                 o_reg_dest,
  output logic [NB_OPCODE-1:0] o_alu_op,
  output logic                 o_alu_src,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic                 o_branch,
  output logic                 o_reg_write,
  output logic                 o_mem_to_reg,
  output logic                 o_byte_en,
  output logic                 o_halfword_en,
  output logic                 o_word_en,
  output logic                 o_jr_jalr,
  output logic                 o_hlt
);

  localparam logic [NB_OPCODE-1:0] OP_RTYPE = NB_OPCODE'('h00);
  localparam logic [NB_OPCODE-1:0] OP_BEQ   = NB_OPCODE'('h04);
  localparam logic [NB_OPCODE-1:0] OP_BNE   = NB_OPCODE'('h05);
  localparam logic [NB_OPCODE-1:0] OP_ADDI  = NB_OPCODE'('h08);
  localparam logic [NB_OPCODE-1:0] OP_SLTI  = NB_OPCODE'('h0a);
  localparam logic [NB_OPCODE-1:0] OP_ANDI  = NB_OPCODE'('h0c);
  localparam logic [NB_OPCODE-1:0] OP_ORI   = NB_OPCODE'('h0d);
  localparam logic [NB_OPCODE-1:0] OP_XORI  = NB_OPCODE'('h0e);
  localparam logic [NB_OPCODE-1:0] OP_LUI   = NB_OPCODE'('h0f);
  localparam logic [NB_OPCODE-1:0] OP_LB    = NB_OPCODE'('h20);
  localparam logic [NB_OPCODE-1:0] OP_LH    = NB_OPCODE'('h21);
  localparam logic [NB_OPCODE-1:0] OP_LHU   = NB_OPCODE'('h22);
  localparam logic [NB_OPCODE-1:0] OP_LW    = NB_OPCODE'('h23);
  localparam logic [NB_OPCODE-1:0] OP_LWU   = NB_OPCODE'('h24);
  localparam logic [NB_OPCODE-1:0] OP_LBU   = NB_OPCODE'('h25);
  localparam logic [NB_OPCODE-1:0] OP_SB    = NB_OPCODE'('h28);
  localparam logic [NB_OPCODE-1:0] OP_SH    = NB_OPCODE'('h29);
  localparam logic [NB_OPCODE-1:0] OP_SW    = NB_OPCODE'('h2b);
  localparam logic [NB_OPCODE-1:0] OP_HLT   = NB_OPCODE'('h3f);

  localparam logic [NB_FUNCT-1:0] FN_JR   = NB_FUNCT'('h08);
  localparam logic [NB_FUNCT-1:0] FN_JALR = NB_FUNCT'('h09);

  logic                 reg_dest;
  logic [NB_OPCODE-1:0] alu_op;
  logic                 alu_src;
  logic                 mem_read;
  logic                 mem_write;
  logic                 branch;
  logic                 reg_write;
  logic                 mem_to_reg;
  logic                 byte_en;
  logic                 halfword_en;
  logic                 word_en;
  logic                 jr_jalr;
  logic                 hlt;

  always_comb begin
    reg_dest    = 1'b0;
    alu_op      = '0;
    alu_src     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    branch      = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    byte_en     = 1'b0;
    halfword_en = 1'b0;
    word_en     = 1'b0;
    jr_jalr     = 1'b0;
    hlt         = 1'b0;

    case (i_opcode)
      OP_RTYPE: begin
        alu_op    = i_opcode;
        reg_dest  = 1'b1;
        reg_write = 1'b1;
        if (i_funct == FN_JR) begin
          jr_jalr   = 1'b1;
          reg_write = 1'b0;
        end else if (i_funct == FN_JALR) begin
          jr_jalr = 1'b1;
        end
      end
      OP_BEQ, OP_BNE: begin
        alu_op = i_opcode;
        branch = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        alu_op    = i_opcode;
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      OP_LB, OP_LH, OP_LHU, OP_LW, OP_LWU, OP_LBU: begin
        alu_op      = i_opcode;
        alu_src     = 1'b1;
        mem_read    = 1'b1;
        mem_to_reg  = 1'b1;
        reg_write   = 1'b1;
        byte_en     = (i_opcode == OP_LB)  || (i_opcode == OP_LBU);
        halfword_en = (i_opcode == OP_LH)  || (i_opcode == OP_LHU);
        word_en     = (i_opcode == OP_LW)  || (i_opcode == OP_LWU);
      end
      OP_SB, OP_SH, OP_SW: begin
        alu_op      = i_opcode;
        alu_src     = 1'b1;
        mem_write   = 1'b1;
        byte_en     = (i_opcode == OP_SB);
        halfword_en = (i_opcode == OP_SH);
        word_en     = (i_opcode == OP_SW);
      end
      OP_HLT: begin
        hlt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_reg_dest    <= 1'b0;
      o_alu_op      <= '0;
      o_alu_src     <= 1'b0;
      o_mem_read    <= 1'b0;
      o_mem_write   <= 1'b0;
      o_branch      <= 1'b0;
      o_reg_write   <= 1'b0;
      o_mem_to_reg  <= 1'b0;
      o_byte_en     <= 1'b0;
      o_halfword_en <= 1'b0;
      o_word_en     <= 1'b0;
      o_jr_jalr     <= 1'b0;
      o_hlt         <= 1'b0;
    end else if (i_enable) begin
      o_reg_dest    <= reg_dest;
      o_alu_op      <= alu_op;
      o_alu_src     <= alu_src;
      o_mem_read    <= mem_read;
      o_mem_write   <= mem_write;
      o_branch      <= branch;
      o_reg_write   <= reg_write;
      o_mem_to_reg  <= mem_to_reg;
      o_byte_en     <= byte_en;
      o_halfword_en <= halfword_en;
      o_word_en     <= word_en;
      o_jr_jalr     <= jr_jalr;
      o_hlt         <= hlt;
    end
  end

endmodule

// File: tb/tb_mips_control_unit.sv
// Directed bench for mips_control_unit: each vector is checked just before the edge
// (previous value still held) and just after it (new decode visible).
module tb_mips_control_unit;

  logic       i_clock = 1'b0;
  logic       i_reset;
  logic       i_enable;
  logic [5:0] i_opcode;
  logic [5:0] i_funct;
  logic       o_reg_dest;
  logic [5:0] o_alu_op;
  logic       o_alu_src;
  logic       o_mem_read;
  logic       o_mem_write;
  logic       o_branch;
  logic       o_reg_write;
  logic       o_mem_to_reg;
  logic       o_byte_en;
  logic       o_halfword_en;
  logic       o_word_en;
  logic       o_jr_jalr;
  logic       o_hlt;

  int vectors     = 0;
  int miscompares = 0;
  logic [17:0] prev;

  mips_control_unit #(.NB_OPCODE(6), .NB_FUNCT(6)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_enable      (i_enable),
    .i_opcode      (i_opcode),
    .i_funct       (i_funct),
    .o_reg_dest    (o_reg_dest),
    .o_alu_op      (o_alu_op),
    .o_alu_src     (o_alu_src),
    .o_mem_read    (o_mem_read),
    .o_mem_write   (o_mem_write),
    .o_branch      (o_branch),
    .o_reg_write   (o_reg_write),
    .o_mem_to_reg  (o_mem_to_reg),
    .o_byte_en     (o_byte_en),
    .o_halfword_en (o_halfword_en),
    .o_word_en     (o_word_en),
    .o_jr_jalr     (o_jr_jalr),
    .o_hlt         (o_hlt)
  );

  always #5 i_clock = ~i_clock;

  // Field order: reg_dest, alu_op, alu_src, mem_read, mem_write, branch,
  // reg_write, mem_to_reg, byte, halfword, word, jr_jalr, hlt
  function automatic logic [17:0] pk(input logic rd, input logic [5:0] aop,
                                     input logic src, input logic mr, input logic mw,
                                     input logic br, input logic rw, input logic m2r,
                                     input logic b, input logic h, input logic w,
                                     input logic jr, input logic hl);
    return {rd, aop, src, mr, mw, br, rw, m2r, b, h, w, jr, hl};
  endfunction

  function automatic logic [17:0] observed();
    return {o_reg_dest, o_alu_op, o_alu_src, o_mem_read, o_mem_write, o_branch,
            o_reg_write, o_mem_to_reg, o_byte_en, o_halfword_en, o_word_en,
            o_jr_jalr, o_hlt};
  endfunction

  task automatic check(input string tag, input logic [17:0] exp);
    logic [17:0] obs;
    obs = observed();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic [17:0] exp);
    i_opcode = op;
    i_funct  = fn;
    #1;
    check({tag, "_pre"}, prev);
    @(posedge i_clock);
    #1;
    check(tag, exp);
    prev = exp;
  endtask

  initial begin
    i_reset  = 1'b1;
    i_enable = 1'b1;
    i_opcode = 6'h23;
    i_funct  = 6'h00;
    repeat (2) @(posedge i_clock);
    #1;
    check("reset", '0);
    prev = '0;
    i_reset = 1'b0;

    apply("r_add", 6'h00, 6'h20, pk(1, 6'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    apply("jalr",  6'h00, 6'h09, pk(1, 6'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    apply("jr",    6'h00, 6'h08, pk(1, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    apply("beq",   6'h04, 6'h00, pk(0, 6'h04, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    apply("bne",   6'h05, 6'h09, pk(0, 6'h05, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    apply("addi",  6'h08, 6'h08, pk(0, 6'h08, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    apply("slti",  6'h0a, 6'h00, pk(0, 6'h0a, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    apply("andi",  6'h0c, 6'h00, pk(0, 6'h0c, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    apply("ori",   6'h0d, 6'h00, pk(0, 6'h0d, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    apply("xori",  6'h0e, 6'h00, pk(0, 6'h0e, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    apply("lui",   6'h0f, 6'h00, pk(0, 6'h0f, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    apply("lb",    6'h20, 6'h00, pk(0, 6'h20, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    apply("lh",    6'h21, 6'h00, pk(0, 6'h21, 1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0));
    apply("lhu",   6'h22, 6'h00, pk(0, 6'h22, 1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0));
    apply("lw",    6'h23, 6'h00, pk(0, 6'h23, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0));
    apply("lwu",   6'h24, 6'h00, pk(0, 6'h24, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0));
    apply("lbu",   6'h25, 6'h00, pk(0, 6'h25, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    apply("sb",    6'h28, 6'h00, pk(0, 6'h28, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    apply("sh",    6'h29, 6'h00, pk(0, 6'h29, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    apply("undef_2a", 6'h2a, 6'h00, '0);
    apply("sw",    6'h2b, 6'h00, pk(0, 6'h2b, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    apply("hlt",   6'h3f, 6'h00, pk(0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    apply("nop_3e", 6'h3e, 6'h08, '0);
    apply("nop_01", 6'h01, 6'h09, '0);
    apply("lw_again", 6'h23, 6'h00, pk(0, 6'h23, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0));

    // Enable low: the lw decode must stay frozen across edges despite a new opcode.
    i_enable = 1'b0;
    i_opcode = 6'h3f;
    repeat (2) @(posedge i_clock);
    #1;
    check("hold", prev);
    i_enable = 1'b1;
    @(posedge i_clock);
    #1;
    check("resume_hlt", pk(0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    // Reset wins even with enable low.
    i_opcode = 6'h23;
    @(posedge i_clock);
    #1;
    check("pre_reset_lw", pk(0, 6'h23, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0));
    i_enable = 1'b0;
    i_reset  = 1'b1;
    @(posedge i_clock);
    #1;
    check("reset_no_en", '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
